// File: rtl/i2c_cmd_sequencer_if.sv
// Request, write-byte, master-burst, read-byte and status signals of the I2C command sequencer.
// The slave modport is the sequencer side; the master modport is the side that drives it.
interface i2c_cmd_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic       req_write;
    logic [3:0] req_len;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] wdata;
    logic       m_canin;
    logic       m_pushin;
    logic [7:0] m_data_in;
    logic       m_pushout;
    logic [7:0] m_data_out;
    logic       rdata_valid;
    logic       rdata_ready;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       rd_overflow;

    modport slave (
        input  req_valid, req_addr, req_write, req_len,
        input  wdata_valid, wdata,
        input  m_canin, m_pushout, m_data_out,
        input  rdata_ready,
        output req_ready, wdata_ready, m_pushin, m_data_in,
        output rdata_valid, rdata, busy, done, timeout, rd_overflow
    );

    modport master (
        output req_valid, req_addr, req_write, req_len,
        output wdata_valid, wdata,
        output m_canin, m_pushout, m_data_out,
        output rdata_ready,
        input  req_ready, wdata_ready, m_pushin, m_data_in,
        input  rdata_valid, rdata, busy, done, timeout, rd_overflow
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Front-end for the single-master I2C controller: queues write bytes, emits each transaction
// as one contiguous header+data pushin burst, and collects read bytes into a ready/valid FIFO.
module i2c_seq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module i2c_cmd_sequencer #(
    parameter int WFIFO_DEPTH = 16,
    parameter int RFIFO_DEPTH = 16,
    parameter int RD_TIMEOUT  = 65535
) (
    input logic                  clk,
    input logic                  rst,
    i2c_cmd_sequencer_if.slave   bus
);
    localparam int WCW = $clog2(WFIFO_DEPTH) + 1;
    localparam int RCW = $clog2(RFIFO_DEPTH) + 1;
    localparam int TW  = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RES, S_HDR, S_BURST, S_RD_WAIT, S_DONE
    } state_t;

    state_t         state, nstate;
    logic           live;
    logic [6:0]     addr_q;
    logic           wr_q;
    logic [3:0]     len_q;
    logic [3:0]     bcnt;
    logic [4:0]     rx_cnt, rx_next;
    logic [TW-1:0]  timer;
    logic           to_q;

    logic [WCW-1:0] wf_cnt;
    logic           wf_full;
    logic [7:0]     wf_head;
    logic [RCW-1:0] rf_cnt, rf_free;
    logic           rf_full;
    logic [7:0]     rf_head;

    logic           acc, res_ok, rx_done, tmo;
    logic           pushin_d, wpop;
    logic [7:0]     data_d;

    i2c_seq_fifo #(.DEPTH(WFIFO_DEPTH), .W(8)) u_wfifo (
        .clk(clk), .rst(rst),
        .push(bus.wdata_valid && bus.wdata_ready), .pop(wpop),
        .din(bus.wdata), .dout(wf_head), .count(wf_cnt), .full(wf_full)
    );

    i2c_seq_fifo #(.DEPTH(RFIFO_DEPTH), .W(8)) u_rfifo (
        .clk(clk), .rst(rst),
        .push(bus.m_pushout), .pop(bus.rdata_valid && bus.rdata_ready),
        .din(bus.m_data_out), .dout(rf_head), .count(rf_cnt), .full(rf_full)
    );

    // live holds the handshakes low through reset and for the first edge after it
    assign bus.wdata_ready = live && !wf_full;
    assign bus.rdata_valid = (rf_cnt != '0);
    assign bus.rdata       = rf_head;

    assign acc     = bus.req_valid && bus.req_ready;
    assign rf_free = RCW'(RFIFO_DEPTH) - rf_cnt;
    assign res_ok  = wr_q ? (wf_cnt >= WCW'(len_q)) : (rf_free >= RCW'(len_q));
    assign rx_next = rx_cnt + {4'd0, bus.m_pushout};
    assign rx_done = (rx_next >= {1'b0, len_q});
    assign tmo     = (timer == TW'(RD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:     if (acc) nstate = S_WAIT_RES;
            S_WAIT_RES: if (res_ok && bus.m_canin) nstate = S_HDR;
            S_HDR:      nstate = (len_q == 4'd0) ? S_DONE : S_BURST;
            S_BURST:    if (bcnt == 4'd1) nstate = wr_q ? S_DONE : S_RD_WAIT;
            S_RD_WAIT:  if (rx_done || tmo) nstate = S_DONE;
            S_DONE:     nstate = S_IDLE;
            default:    nstate = S_IDLE;
        endcase
    end

    always_comb begin
        pushin_d      = (state == S_HDR) || (state == S_BURST);
        wpop          = (state == S_BURST) && wr_q;
        data_d        = 8'h00;
        if (state == S_HDR) data_d = {addr_q, wr_q};
        else if (wpop)      data_d = wf_head;
        bus.req_ready = live && (state == S_IDLE);
        bus.busy      = (state != S_IDLE);
        bus.done      = (state == S_DONE);
        bus.timeout   = (state == S_DONE) && to_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live            <= 1'b0;
            bus.m_pushin    <= 1'b0;
            bus.m_data_in   <= 8'h00;
            bus.rd_overflow <= 1'b0;
            addr_q          <= '0;
            wr_q            <= 1'b0;
            len_q           <= '0;
            bcnt            <= '0;
            rx_cnt          <= '0;
            timer           <= '0;
            to_q            <= 1'b0;
        end else begin
            live          <= 1'b1;
            bus.m_pushin  <= pushin_d;
            bus.m_data_in <= data_d;
            if (acc) begin
                addr_q <= bus.req_addr;
                wr_q   <= bus.req_write;
                len_q  <= bus.req_len;
                rx_cnt <= '0;
                to_q   <= 1'b0;
            end
            if (state == S_HDR)        bcnt <= len_q;
            else if (state == S_BURST) bcnt <= bcnt - 1'b1;
            // read bytes may come back while the zero-filled count words are still going out
            if ((state == S_BURST || state == S_RD_WAIT) && bus.m_pushout) rx_cnt <= rx_next;
            timer <= (state == S_RD_WAIT) ? timer + 1'b1 : '0;
            if (state == S_RD_WAIT && tmo && !rx_done) to_q <= 1'b1;
            if (bus.m_pushout && rf_full) bus.rd_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: table of transactions plus hand-written stall, overflow,
// timeout and mid-burst reset sequences; burst words and read bytes checked from queues.
module tb_i2c_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if bus();
    i2c_cmd_sequencer #(.WFIFO_DEPTH(16), .RFIFO_DEPTH(16), .RD_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [3:0] len;
        logic [7:0] hdr;
        logic [7:0] seed;
    } vec_t;

    vec_t       vecs [6];
    int         n_vec = 0, n_err = 0, n_done = 0, n_to = 0;
    int         cyc = 0, last_p = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] wf_model [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_pushin) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL burst_extra: word 0x%0h with nothing expected", bus.m_data_in);
                end else chk("burst_word", 32'(bus.m_data_in), 32'(exp_q.pop_front()));
            end
            if (bus.rdata_valid && bus.rdata_ready) begin
                if (rd_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rdata_extra: byte 0x%0h with nothing expected", bus.rdata);
                end else chk("rdata", 32'(bus.rdata), 32'(rd_q.pop_front()));
            end
            if (bus.done)    n_done++;
            if (bus.timeout) n_to++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wpush(input logic [7:0] b);
        bus.wdata_valid = 1'b1;
        bus.wdata       = b;
        chk("wdata_ready", 32'(bus.wdata_ready), 1);
        step();
        bus.wdata_valid = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] seed, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = seed + 8'(i * 17);
            wf_model.push_back(b);
            wpush(b);
        end
    endtask

    task automatic mpush(input logic [7:0] b, input bit stored);
        bus.m_pushout  = 1'b1;
        bus.m_data_out = b;
        step();
        bus.m_pushout  = 1'b0;
        if (stored) rd_q.push_back(b);
    endtask

    task automatic issue(input vec_t v);
        exp_q.push_back(v.hdr);
        for (int i = 0; i < int'(v.len); i++)
            exp_q.push_back(v.wr ? wf_model.pop_front() : 8'h00);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_write = v.wr;
        bus.req_len   = v.len;
        chk("req_ready", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic burst_len(input int exp_n, input string name);
        int g = 0, n = 0;
        while (!bus.m_pushin && g < 60) begin step(); g++; end
        while (bus.m_pushin && n < 40) begin n++; last_p = cyc; step(); end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_done(input int d0, input string name);
        int g = 0;
        while (n_done == d0 && g < 300) begin step(); g++; end
        chk(name, 32'(n_done - d0), 1);
    endtask

    task automatic drain();
        int g = 0;
        bus.rdata_ready = 1'b1;
        while (rd_q.size() > 0 && g < 100) begin step(); g++; end
        bus.rdata_ready = 1'b0;
        chk("rdata_left", 32'(rd_q.size()), 0);
        chk("rdata_valid_empty", 32'(bus.rdata_valid), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int d0 = n_done, t0 = n_to;
        if (v.wr) load_bytes(v.seed, int'(v.len));
        issue(v);
        burst_len(int'(v.len) + 1, "burst_len");
        if (!v.wr)
            for (int i = 0; i < int'(v.len); i++) mpush(v.seed + 8'(i * 17), 1'b1);
        wait_done(d0, "done_pulse");
        chk("busy_after", 32'(bus.busy), 0);
        chk("no_timeout", 32'(n_to - t0), 0);
        drain();
    endtask

    initial begin
        vec_t v;
        int   p, d0, t0, g, dcyc;
        vecs[0] = '{1'b1, 7'd25,  4'd5, 8'h33, 8'hA1};
        vecs[1] = '{1'b0, 7'd25,  4'd3, 8'h32, 8'h11};
        vecs[2] = '{1'b1, 7'h07,  4'd1, 8'h0F, 8'h5A};
        vecs[3] = '{1'b0, 7'h7F,  4'd2, 8'hFE, 8'hC0};
        vecs[4] = '{1'b1, 7'h40,  4'd0, 8'h81, 8'h00};
        vecs[5] = '{1'b0, 7'h13,  4'd0, 8'h26, 8'h00};

        bus.req_valid = 0; bus.req_addr = 0; bus.req_write = 0; bus.req_len = 0;
        bus.wdata_valid = 0; bus.wdata = 0; bus.m_canin = 1; bus.m_pushout = 0;
        bus.m_data_out = 0; bus.rdata_ready = 0;

        // reset state
        step(); step();
        chk("rst_req_ready",   32'(bus.req_ready), 0);
        chk("rst_wdata_ready", 32'(bus.wdata_ready), 0);
        chk("rst_pushin",      32'(bus.m_pushin), 0);
        chk("rst_data_in",     32'(bus.m_data_in), 0);
        chk("rst_rdata_valid", 32'(bus.rdata_valid), 0);
        chk("rst_busy",        32'(bus.busy), 0);
        chk("rst_done",        32'(bus.done), 0);
        chk("rst_timeout",     32'(bus.timeout), 0);
        chk("rst_overflow",    32'(bus.rd_overflow), 0);
        rst = 1'b0;
        chk("wdata_ready_hold", 32'(bus.wdata_ready), 0);
        step();
        chk("wdata_ready_up", 32'(bus.wdata_ready), 1);
        chk("req_ready_up",   32'(bus.req_ready), 1);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // write stalls for a missing byte, then for m_canin
        v = '{1'b1, 7'h0C, 4'd3, 8'h19, 8'h70};
        d0 = n_done;
        for (int i = 0; i < 3; i++) wf_model.push_back(8'h70 + 8'(i * 17));
        wpush(8'h70); wpush(8'h81);
        issue(v);
        p = 0;
        repeat (8) begin step(); p += int'(bus.m_pushin); end
        chk("wait_bytes_no_burst", 32'(p), 0);
        chk("wait_bytes_busy", 32'(bus.busy), 1);
        bus.m_canin = 1'b0;
        wpush(8'h92);
        repeat (8) begin step(); p += int'(bus.m_pushin); end
        chk("canin_low_no_burst", 32'(p), 0);
        bus.m_canin = 1'b1;
        burst_len(4, "stall_burst_len");
        wait_done(d0, "stall_done");

        // read space reservation and overflow
        v = '{1'b0, 7'h05, 4'd15, 8'h0A, 8'h00};
        for (int i = 0; i < 10; i++) mpush(8'h20 + 8'(i), 1'b1);
        d0 = n_done;
        issue(v);
        p = 0;
        repeat (10) begin step(); p += int'(bus.m_pushin); end
        chk("rspace_no_burst", 32'(p), 0);
        bus.rdata_ready = 1'b1;
        repeat (9) step();
        bus.rdata_ready = 1'b0;
        burst_len(16, "rd15_burst_len");
        for (int i = 0; i < 15; i++) mpush(8'h40 + 8'(i * 3), 1'b1);
        wait_done(d0, "rd15_done");
        chk("no_overflow_yet", 32'(bus.rd_overflow), 0);
        mpush(8'hEE, 1'b0);
        chk("overflow_set", 32'(bus.rd_overflow), 1);
        drain();
        chk("overflow_sticky", 32'(bus.rd_overflow), 1);

        // read with no response times out
        v = '{1'b0, 7'h11, 4'd2, 8'h22, 8'h00};
        d0 = n_done; t0 = n_to;
        issue(v);
        burst_len(3, "to_burst_len");
        g = 0;
        while (!bus.done && g < 300) begin step(); g++; end
        dcyc = cyc;
        chk("timeout_latency", 32'(dcyc - last_p), 100);
        chk("timeout_with_done", 32'(bus.timeout), 1);
        step();
        chk("to_busy_after", 32'(bus.busy), 0);
        chk("to_timeout_low", 32'(bus.timeout), 0);
        chk("to_pulse_count", 32'(n_to - t0), 1);
        chk("to_done_count", 32'(n_done - d0), 1);

        // reset during the third data word of a write burst
        v = '{1'b1, 7'h2A, 4'd5, 8'h55, 8'h30};
        d0 = n_done;
        load_bytes(8'h30, 8);
        issue(v);
        g = 0;
        while (!bus.m_pushin && g < 60) begin step(); g++; end
        repeat (3) step();
        chk("pre_rst_pushin", 32'(bus.m_pushin), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_pushin", 32'(bus.m_pushin), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_overflow", 32'(bus.rd_overflow), 0);
        chk("mid_rst_rvalid", 32'(bus.rdata_valid), 0);
        exp_q.delete();
        wf_model.delete();
        step();
        chk("post_rst_wready", 32'(bus.wdata_ready), 1);
        chk("mid_rst_no_done", 32'(n_done - d0), 0);
        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
